// File: rtl/atm_keypad_entry.sv
// ATM keypad front end: collects operation, account, PIN and optional amount / new PIN as
// binary fields and presents one complete request with a single-cycle req_valid_o strobe.
module atm_keypad_entry #(
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        key_valid_i,
   input  logic [3:0]  key_code_i,
   output logic [2:0]  operation_o,
   output logic [3:0]  acc_num_o,
   output logic [15:0] pin_o,
   output logic [15:0] amount_o,
   output logic [15:0] new_pin_o,
   output logic        language_o,
   output logic        req_valid_o,
   output logic [2:0]  entry_state_o,
   output logic        err_o,
   output logic        timeout_o
);

   typedef enum logic [2:0] {
      StOp   = 3'd0,
      StAcc  = 3'd1,
      StPin  = 3'd2,
      StAmt  = 3'd3,
      StNpin = 3'd4,
      StSend = 3'd5
   } state_e;

   localparam logic [3:0] KeyClear  = 4'd10;
   localparam logic [3:0] KeyEnter  = 4'd11;
   localparam logic [3:0] KeyCancel = 4'd12;
   localparam logic [3:0] KeyLang   = 4'd13;

   localparam int unsigned   CntW    = $clog2(TIMEOUT_CYC);
   localparam logic [CntW-1:0] TmrLast = CntW'(TIMEOUT_CYC - 1);

   state_e          state_q, state_d;
   logic [16:0]     cur_val_q, cur_val_d;
   logic [2:0]      dig_cnt_q, dig_cnt_d;
   logic [2:0]      sh_op_q, sh_op_d;
   logic [3:0]      sh_acc_q, sh_acc_d;
   logic [15:0]     sh_pin_q, sh_pin_d;
   logic [15:0]     sh_amt_q, sh_amt_d;
   logic [15:0]     sh_npin_q, sh_npin_d;
   logic [2:0]      op_q, op_d;
   logic [3:0]      acc_q, acc_d;
   logic [15:0]     pin_q, pin_d;
   logic [15:0]     amt_q, amt_d;
   logic [15:0]     npin_q, npin_d;
   logic            lang_q, lang_d;
   logic            req_q, req_d;
   logic            err_q, err_d;
   logic            to_q, to_d;
   logic [CntW-1:0] tmr_q, tmr_d;

   logic [2:0]  max_dig;
   logic [16:0] limit;
   logic [20:0] cand;
   logic        dig_ok;
   logic        entry_st;
   logic        abort;
   logic        go_send;

   always_comb begin
      max_dig = 3'd0;
      limit   = 17'd0;
      case (state_q)
         StOp:    begin max_dig = 3'd1; limit = 17'd7;     end
         StAcc:   begin max_dig = 3'd2; limit = 17'd15;    end
         StPin:   begin max_dig = 3'd4; limit = 17'd9999;  end
         StAmt:   begin max_dig = 3'd5; limit = 17'd65535; end
         StNpin:  begin max_dig = 3'd4; limit = 17'd9999;  end
         default: ;
      endcase
   end

   assign cand     = 21'(cur_val_q) * 21'd10 + 21'(key_code_i);
   assign dig_ok   = (dig_cnt_q < max_dig) && (cand <= 21'(limit));
   assign entry_st = state_q inside {StOp, StAcc, StPin, StAmt, StNpin};

   always_comb begin
      state_d   = state_q;
      cur_val_d = cur_val_q;
      dig_cnt_d = dig_cnt_q;
      sh_op_d   = sh_op_q;
      sh_acc_d  = sh_acc_q;
      sh_pin_d  = sh_pin_q;
      sh_amt_d  = sh_amt_q;
      sh_npin_d = sh_npin_q;
      op_d      = op_q;
      acc_d     = acc_q;
      pin_d     = pin_q;
      amt_d     = amt_q;
      npin_d    = npin_q;
      lang_d    = lang_q;
      tmr_d     = tmr_q;
      req_d     = 1'b0;
      err_d     = 1'b0;
      to_d      = 1'b0;
      abort     = 1'b0;
      go_send   = 1'b0;

      // Any key restarts the idle window, so a key on the expiry cycle wins.
      case (state_q)
         StAcc, StPin, StAmt, StNpin: begin
            if (key_valid_i) begin
               tmr_d = '0;
            end else if (tmr_q == TmrLast) begin
               to_d  = 1'b1;
               abort = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: tmr_d = '0;
      endcase

      if (key_valid_i && entry_st) begin
         if (key_code_i <= 4'd9) begin
            if (dig_ok) begin
               cur_val_d = cand[16:0];
               dig_cnt_d = dig_cnt_q + 3'd1;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            case (key_code_i)
               KeyClear: begin
                  cur_val_d = '0;
                  dig_cnt_d = '0;
               end
               KeyEnter: begin
                  if (dig_cnt_q == 3'd0) begin
                     err_d = 1'b1;
                  end else begin
                     cur_val_d = '0;
                     dig_cnt_d = '0;
                     case (state_q)
                        StOp: begin
                           if (cur_val_q <= 17'd4) begin
                              sh_op_d = cur_val_q[2:0];
                              state_d = StAcc;
                           end else begin
                              err_d = 1'b1;
                           end
                        end
                        StAcc: begin
                           sh_acc_d = cur_val_q[3:0];
                           state_d  = StPin;
                        end
                        StPin: begin
                           sh_pin_d = cur_val_q[15:0];
                           if (sh_op_q == 3'd2 || sh_op_q == 3'd3) begin
                              state_d = StAmt;
                           end else if (sh_op_q == 3'd4) begin
                              state_d = StNpin;
                           end else begin
                              go_send = 1'b1;
                           end
                        end
                        StAmt: begin
                           sh_amt_d = cur_val_q[15:0];
                           go_send  = 1'b1;
                        end
                        StNpin: begin
                           sh_npin_d = cur_val_q[15:0];
                           go_send   = 1'b1;
                        end
                        default: ;
                     endcase
                  end
               end
               KeyCancel: abort = 1'b1;
               KeyLang: begin
                  if (state_q == StOp) lang_d = ~lang_q;
                  else                 err_d  = 1'b1;
               end
               default: ;
            endcase
         end
      end

      // Outputs load together with the last shadow so the request is visible with req_valid.
      if (go_send) begin
         state_d = StSend;
         req_d   = 1'b1;
         op_d    = sh_op_d;
         acc_d   = sh_acc_d;
         pin_d   = sh_pin_d;
         amt_d   = sh_amt_d;
         npin_d  = sh_npin_d;
      end

      if (state_q == StSend) begin
         state_d   = StOp;
         sh_op_d   = '0;
         sh_acc_d  = '0;
         sh_pin_d  = '0;
         sh_amt_d  = '0;
         sh_npin_d = '0;
      end else if (!entry_st) begin
         abort = 1'b1;
      end

      if (abort) begin
         state_d   = StOp;
         cur_val_d = '0;
         dig_cnt_d = '0;
         sh_op_d   = '0;
         sh_acc_d  = '0;
         sh_pin_d  = '0;
         sh_amt_d  = '0;
         sh_npin_d = '0;
         tmr_d     = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StOp;
         cur_val_q <= '0;
         dig_cnt_q <= '0;
         sh_op_q   <= '0;
         sh_acc_q  <= '0;
         sh_pin_q  <= '0;
         sh_amt_q  <= '0;
         sh_npin_q <= '0;
         op_q      <= '0;
         acc_q     <= '0;
         pin_q     <= '0;
         amt_q     <= '0;
         npin_q    <= '0;
         lang_q    <= 1'b0;
         req_q     <= 1'b0;
         err_q     <= 1'b0;
         to_q      <= 1'b0;
         tmr_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_val_q <= cur_val_d;
         dig_cnt_q <= dig_cnt_d;
         sh_op_q   <= sh_op_d;
         sh_acc_q  <= sh_acc_d;
         sh_pin_q  <= sh_pin_d;
         sh_amt_q  <= sh_amt_d;
         sh_npin_q <= sh_npin_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         pin_q     <= pin_d;
         amt_q     <= amt_d;
         npin_q    <= npin_d;
         lang_q    <= lang_d;
         req_q     <= req_d;
         err_q     <= err_d;
         to_q      <= to_d;
         tmr_q     <= tmr_d;
      end
   end

   assign operation_o   = op_q;
   assign acc_num_o     = acc_q;
   assign pin_o         = pin_q;
   assign amount_o      = amt_q;
   assign new_pin_o     = npin_q;
   assign language_o    = lang_q;
   assign req_valid_o   = req_q;
   assign entry_state_o = state_q;
   assign err_o         = err_q;
   assign timeout_o     = to_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// Directed, table-driven bench for atm_keypad_entry: each row is one cycle of key input
// plus the outputs expected after that edge.
module tb_atm_keypad_entry;

   localparam logic [3:0] CLR = 4'd10;
   localparam logic [3:0] ENT = 4'd11;
   localparam logic [3:0] CAN = 4'd12;
   localparam logic [3:0] LNG = 4'd13;

   typedef struct {
      logic        v;
      logic [3:0]  code;
      logic [2:0]  st;
      logic        err;
      logic        to;
      logic        req;
      logic        lang;
      logic [54:0] fields;   // {op, acc, pin, amount, new_pin}
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [2:0]  operation;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [15:0] amount;
   logic [15:0] new_pin;
   logic        language;
   logic        req_valid;
   logic [2:0]  entry_state;
   logic        err;
   logic        timeout;

   vec_t        tbl[$];
   logic        b_lang = 1'b0;
   logic [54:0] exp_fields = '0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          row = 0;

   always #5 clk = ~clk;

   atm_keypad_entry #(
      .TIMEOUT_CYC (8)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .key_valid_i   (key_valid),
      .key_code_i    (key_code),
      .operation_o   (operation),
      .acc_num_o     (acc_num),
      .pin_o         (pin),
      .amount_o      (amount),
      .new_pin_o     (new_pin),
      .language_o    (language),
      .req_valid_o   (req_valid),
      .entry_state_o (entry_state),
      .err_o         (err),
      .timeout_o     (timeout)
   );

   task automatic chk(input string name, input int r, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, r, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [3:0] code, input logic [2:0] st,
                      input logic e, input logic to);
      vec_t x;
      x = '{v, code, st, e, to, 1'b0, b_lang, 55'd0};
      tbl.push_back(x);
   endtask

   task automatic kd(input logic [3:0] code, input logic [2:0] st);
      add(1'b1, code, st, 1'b0, 1'b0);
   endtask

   task automatic ke(input logic [3:0] code, input logic [2:0] st);
      add(1'b1, code, st, 1'b1, 1'b0);
   endtask

   task automatic idle(input logic [2:0] st, input logic to);
      add(1'b0, 4'd0, st, 1'b0, to);
   endtask

   task automatic snd(input logic [2:0] op, input logic [3:0] acc, input logic [15:0] p,
                      input logic [15:0] amt, input logic [15:0] np);
      vec_t x;
      x = '{1'b1, ENT, 3'd5, 1'b0, 1'b0, 1'b1, b_lang, {op, acc, p, amt, np}};
      tbl.push_back(x);
   endtask

   task automatic run();
      foreach (tbl[i]) begin
         key_valid = tbl[i].v;
         key_code  = tbl[i].code;
         @(negedge clk);
         key_valid = 1'b0;
         key_code  = 4'd0;
         if (tbl[i].req) exp_fields = tbl[i].fields;
         chk("entry_state", row, 64'(entry_state), 64'(tbl[i].st));
         chk("err", row, 64'(err), 64'(tbl[i].err));
         chk("timeout", row, 64'(timeout), 64'(tbl[i].to));
         chk("req_valid", row, 64'(req_valid), 64'(tbl[i].req));
         chk("language", row, 64'(language), 64'(tbl[i].lang));
         chk("request_fields", row, 64'({operation, acc_num, pin, amount, new_pin}),
             64'(exp_fields));
         row++;
      end
      tbl.delete();
   endtask

   task automatic chk_reset(input int tag);
      chk("rst_state", tag, 64'(entry_state), 64'd0);
      chk("rst_fields", tag, 64'({operation, acc_num, pin, amount, new_pin}), 64'd0);
      chk("rst_language", tag, 64'(language), 64'd0);
      chk("rst_req_valid", tag, 64'(req_valid), 64'd0);
      chk("rst_err", tag, 64'(err), 64'd0);
      chk("rst_timeout", tag, 64'(timeout), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      #2 chk_reset(0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Withdrawal: op 3, acc 1, pin 1234, amount 90
      kd(4'd3, 3'd0); kd(ENT, 3'd1); kd(4'd1, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd2, 3'd2); kd(4'd3, 3'd2); kd(4'd4, 3'd2); kd(ENT, 3'd3);
      kd(4'd9, 3'd3); kd(4'd0, 3'd3); snd(3'd3, 4'd1, 16'd1234, 16'd90, 16'd0);
      idle(3'd0, 1'b0);
      // PIN change, then a key in the send cycle is dropped
      kd(4'd4, 3'd0); kd(ENT, 3'd1); kd(4'd2, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(ENT, 3'd4);
      kd(4'd5, 3'd4); kd(4'd6, 3'd4); kd(4'd7, 3'd4); kd(4'd8, 3'd4);
      snd(3'd4, 4'd2, 16'd1111, 16'd0, 16'd5678);
      kd(4'd1, 3'd0); ke(ENT, 3'd0);
      // Error keys in S_OP
      kd(4'd7, 3'd0); ke(ENT, 3'd0); ke(ENT, 3'd0); ke(4'd8, 3'd0); kd(4'd14, 3'd0);
      ke(ENT, 3'd0); kd(4'd1, 3'd0); ke(4'd2, 3'd0); kd(CLR, 3'd0); ke(ENT, 3'd0);
      b_lang = 1'b1;
      kd(LNG, 3'd0);
      // Range checks: acc 16 rejected, 5th PIN digit, LANG outside S_OP, amount 65535
      kd(4'd2, 3'd0); kd(ENT, 3'd1); kd(4'd1, 3'd1); ke(4'd6, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd2, 3'd2); kd(4'd3, 3'd2); kd(4'd4, 3'd2); ke(4'd5, 3'd2);
      ke(LNG, 3'd2); kd(ENT, 3'd3);
      kd(4'd6, 3'd3); kd(4'd5, 3'd3); kd(4'd5, 3'd3); kd(4'd3, 3'd3); kd(4'd5, 3'd3);
      snd(3'd2, 4'd1, 16'd1234, 16'd65535, 16'd0);
      idle(3'd0, 1'b0);
      // Amount 65536 rejected on last digit
      kd(4'd3, 3'd0); kd(ENT, 3'd1); kd(4'd7, 3'd1); kd(ENT, 3'd2);
      kd(4'd0, 3'd2); kd(4'd0, 3'd2); kd(4'd0, 3'd2); kd(4'd0, 3'd2); kd(ENT, 3'd3);
      kd(4'd6, 3'd3); kd(4'd5, 3'd3); kd(4'd5, 3'd3); kd(4'd3, 3'd3); ke(4'd6, 3'd3);
      snd(3'd3, 4'd7, 16'd0, 16'd6553, 16'd0);
      idle(3'd0, 1'b0);
      // Balance-style op 0 goes straight to send after PIN; stale amount must be zero
      kd(4'd0, 3'd0); kd(ENT, 3'd1); kd(4'd9, 3'd1); kd(ENT, 3'd2); kd(4'd4, 3'd2);
      snd(3'd0, 4'd9, 16'd4, 16'd0, 16'd0);
      idle(3'd0, 1'b0);
      run();

      // Timeout after account entry
      kd(4'd1, 3'd0); kd(ENT, 3'd1); kd(4'd3, 3'd1); kd(ENT, 3'd2);
      for (int i = 0; i < 7; i++) idle(3'd2, 1'b0);
      idle(3'd0, 1'b1);
      for (int i = 0; i < 10; i++) idle(3'd0, 1'b0);
      ke(ENT, 3'd0);
      // Key on the expiry cycle wins
      kd(4'd1, 3'd0); kd(ENT, 3'd1); kd(4'd3, 3'd1); kd(ENT, 3'd2);
      for (int i = 0; i < 7; i++) idle(3'd2, 1'b0);
      kd(4'd5, 3'd2);
      for (int i = 0; i < 7; i++) idle(3'd2, 1'b0);
      idle(3'd0, 1'b1);
      idle(3'd0, 1'b0);
      run();

      // CANCEL mid-PIN keeps previous outputs, then a clean PIN-change entry
      kd(4'd1, 3'd0); kd(ENT, 3'd1); kd(4'd3, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd2, 3'd2); kd(CAN, 3'd0); ke(ENT, 3'd0);
      kd(4'd4, 3'd0); kd(ENT, 3'd1); kd(4'd5, 3'd1); kd(ENT, 3'd2); kd(4'd7, 3'd2);
      kd(ENT, 3'd4); kd(4'd3, 3'd4);
      snd(3'd4, 4'd5, 16'd7, 16'd0, 16'd3);
      idle(3'd0, 1'b0);
      // Partial entry up to the amount field
      kd(4'd2, 3'd0); kd(ENT, 3'd1); kd(4'd1, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(ENT, 3'd3);
      kd(4'd5, 3'd3);
      run();

      // Asynchronous reset mid-amount entry
      #2 rst_n = 1'b0;
      #1 chk_reset(1);
      @(negedge clk);
      rst_n      = 1'b1;
      b_lang     = 1'b0;
      exp_fields = '0;
      idle(3'd0, 1'b0); idle(3'd0, 1'b0);
      ke(ENT, 3'd0);
      kd(4'd2, 3'd0); kd(ENT, 3'd1); kd(4'd1, 3'd1); kd(ENT, 3'd2);
      kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(4'd1, 3'd2); kd(ENT, 3'd3);
      kd(4'd5, 3'd3);
      snd(3'd2, 4'd1, 16'd1111, 16'd5, 16'd0);
      idle(3'd0, 1'b0);
      run();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front end for the ATM core. Accepts one decoded key code per cycle, walks the customer through operation, account, PIN and, when the operation needs them, amount or new PIN. It accumulates each field as a binary value (typed "1234" becomes 16'd1234). It then presents one complete, stable request to the ATM core with a single-cycle `req_valid` strobe.

## Interface
- `TIMEOUT_CYC`, default 1000: idle cycles without an accepted key before an in-progress entry is abandoned. Minimum 2.
- `clk`  in  1: system clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `key_valid`  in  1: key strobe; `key_code` sampled when high.
- `key_code`  in  4: 0–9 digit, 10 CLEAR, 11 ENTER, 12 CANCEL, 13 LANG, 14–15 ignored.
- `operation`  out  3: registered request field.
- `acc_num`  out  4: registered request field.
- `pin`  out  16: registered request field.
- `amount`  out  16: registered request field.
- `new_pin`  out  16: registered request field.
- `language`  out  1: language select, toggled by LANG.
- `req_valid`  out  1: one-cycle strobe; request outputs are valid and held until the next strobe.
- `entry_state`  out  3: current FSM state, for the display.
- `err`  out  1: one-cycle pulse on a rejected key.
- `timeout`  out  1: one-cycle pulse on abandonment.

## Operation
- States:
  - S_OP=0, S_ACC=1, S_PIN=2, S_AMT=3, S_NPIN=4, S_SEND=5.
  - Codes 6–7 are unused and recover to S_OP.
- Working registers: `cur_val` (17 bits internal) and `dig_cnt` (3 bits) for the field being typed, plus shadow copies of each field.
- Digit d accepted only if both hold; otherwise `err` pulses and `cur_val` is unchanged:
  - `dig_cnt` < field max: op 1, acc 2, pin 4, amt 5, npin 4.
  - `cur_val*10+d` ≤ field limit: op 7, acc 15, pin 9999, amt 65535, npin 9999.
- Accepted digit: `cur_val ← cur_val*10+d`, `dig_cnt++`.
- CLEAR: `cur_val ← 0`, `dig_cnt ← 0`; state unchanged.
- ENTER with `dig_cnt`=0: `err` pulses, no transition.
- ENTER, otherwise: current field is stored to its shadow, `cur_val` and `dig_cnt` are cleared, and the state moves on:
  - S_OP: value 0–4 → S_ACC. Value 5–7 → `err`, field cleared, stay in S_OP.
  - S_ACC → S_PIN.
  - S_PIN → S_AMT if op ∈ {2,3}; S_NPIN if op = 4; else S_SEND.
  - S_AMT → S_SEND. S_NPIN → S_SEND.
- Shadows of fields not entered this transaction are zero at send.
- S_SEND:
  - Copy shadows to the output registers and assert `req_valid`.
  - Next cycle go to S_OP and clear all shadows.
  - Keys are ignored while in S_SEND.
- CANCEL in any state except S_SEND: clear `cur_val`, `dig_cnt` and all shadows, go to S_OP. No `err`, and the outputs keep their last sent values.
- LANG: toggles `language` in S_OP only. In other states it produces `err`.
- Codes 14–15 are ignored silently.
- Timeout counter:
  - Clears on every `key_valid`.
  - Counts in S_ACC, S_PIN, S_AMT and S_NPIN.
  - Held at 0 in S_OP and S_SEND.
  - On reaching `TIMEOUT_CYC`-1 with no key that cycle: `timeout` pulses and the block does the same as CANCEL.

## Timing
- Reset (async assert, sync release): every output and internal register is 0, state is S_OP.
- Key processed on the edge where `key_valid`=1; the new `cur_val` or state is visible the next cycle.
- Final ENTER at edge N:
  - S_SEND from N+1.
  - Outputs updated and `req_valid`=1 during N+1.
  - S_OP from N+2.
- Back-to-back keys, one per cycle, are all processed.
- A key in the S_SEND cycle is dropped.
- Key in the same cycle as timeout expiry: the key wins, the counter clears, and there is no `timeout`.
- `err` and `timeout` are never high for more than one consecutive cycle per event.
- Reset asserted mid-entry: immediate return to the reset values. A partially entered request is never sent.

## Test plan
- Withdrawal entry:
  - Keys: 3,ENT,1,ENT,1,2,3,4,ENT,9,0,ENT.
  - Expect `req_valid` exactly 1 cycle after the last ENTER, with op=3, acc=1, pin=1234, amount=90, new_pin=0, then `entry_state`=0.
- PIN change:
  - Keys: 4,ENT,2,ENT,1,1,1,1,ENT,5,6,7,8,ENT.
  - Expect op=4, new_pin=5678, amount=0.
- Range checks:
  - acc keys 1,6: second key gives `err`, acc value stays 1.
  - PIN 5th digit gives `err`.
  - amount 6,5,5,3,5 accepted (65535).
  - amount 6,5,5,3,6 gives `err` on the last key, value 6553.
- Error keys:
  - op 7 + ENT: `err`, stays in S_OP.
  - ENT with empty field: `err`.
  - LANG in S_OP toggles `language`; LANG in S_PIN gives `err`.
- TIMEOUT_CYC=8:
  - Stop after acc entry: `timeout` pulses 8 cycles after the last key, state S_OP, no `req_valid`.
  - Key at the 8th cycle: no `timeout`.
- CANCEL mid-PIN:
  - Expect S_OP, and the previous request outputs unchanged.
- Reset mid-amount entry:
  - Expect all outputs 0 immediately, and the next full entry works.
